// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_pkg
// Purpose  : Shared definitions for the sipo serial receiver. The FSM state
//            encoding is one-hot so it lines up with the upstream piso
//            serializer's state style.
// Revision : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_STALL = 3'b100
  } state_t;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock circular-buffer FIFO with first-word fall-through
//            read data. The pointers carry one extra wrap bit so that the full
//            and empty states can be told apart.
// Ports    : i_clk       clock
//            i_rst_n     asynchronous active-low reset
//            i_push      write request (ignored when full unless popping)
//            i_push_data write data
//            i_pop       read request (ignored when empty)
//            o_data      word at the head of the FIFO
//            o_full      FIFO holds DEPTH words
//            o_empty     FIFO holds no words
//            o_count     current occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/sipo.sv
`default_nettype none
// ============================================================================
// Module   : sipo
// Purpose  : Serial-in, parallel-out receiver. Accepts one bit per cycle over
//            a valid/ready handshake, assembles WIDTH-bit words and buffers
//            them in a small FIFO for a parallel valid/ready consumer. When
//            the FIFO cannot take a completed word it is parked in a hold
//            register and the serial side is stalled via ready_o.
// Ports    : sclk_i   serial clock (only clock of the block)
//            rst_n_i  asynchronous active-low reset
//            data_i   serial data bit
//            valid_i  serial bit valid
//            ready_o  block can accept a serial bit
//            data_o   parallel word at FIFO head
//            valid_o  FIFO non-empty
//            ready_i  consumer accepts the word
//            fill_o   FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module sipo
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    sclk_i,
  input  logic                    rst_n_i,
  input  logic                    data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [$clog2(DEPTH):0]  fill_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_hold;
  logic [WIDTH-1:0]   w_sh_next;
  logic [WIDTH-1:0]   w_push_data;
  logic               w_accept;
  logic               w_last;
  logic               w_space;
  logic               w_push;
  logic               w_hold_load;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;

  // Decode of the state register only; nothing from ready_i reaches here.
  assign ready_o  = (r_state != S_STALL);
  assign w_accept = valid_i && ready_o;
  assign w_last   = w_accept && (r_bit_cnt == C_LAST);
  assign w_pop    = ready_i && !w_fifo_empty;
  // A pop on the same edge frees a slot even when the FIFO is full.
  assign w_space  = !w_fifo_full || w_pop;
  assign valid_o  = !w_fifo_empty;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sh_next = {r_sh[WIDTH-2:0], data_i};
    end else begin : g_lsb_first
      assign w_sh_next = {data_i, r_sh[WIDTH-1:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and push control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_push_data  = w_sh_next;
    w_hold_load  = 1'b0;
    case (r_state)
      S_IDLE, S_SHIFT: begin
        if (w_accept) begin
          if (w_last) begin
            if (w_space) begin
              w_push       = 1'b1;
              w_state_next = S_IDLE;
            end else begin
              w_hold_load  = 1'b1;
              w_state_next = S_STALL;
            end
          end else begin
            w_state_next = S_SHIFT;
          end
        end
      end
      S_STALL: begin
        if (w_space) begin
          w_push       = 1'b1;
          w_push_data  = r_hold;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit counter, shift register and hold register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bit_cnt <= '0;
      r_sh      <= '0;
      r_hold    <= '0;
    end else begin
      if (w_accept) begin
        r_sh      <= w_sh_next;
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_hold_load) begin
        r_hold <= w_sh_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (sclk_i),
    .i_rst_n     (rst_n_i),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_data      (data_o),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (fill_o)
  );

endmodule : sipo
`default_nettype wire

// File: tb/tb_sipo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo
// Purpose  : Self-checking bench for sipo. One MSB-first and one LSB-first
//            instance share clock and reset. Expected words are queued when
//            their last serial bit is accepted and compared when popped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo;

  logic       sclk = 1'b0;
  logic       rst_n;
  // MSB-first instance
  logic       data_i, valid_i, ready_i;
  logic       ready_o, valid_o;
  logic [7:0] data_o;
  logic [2:0] fill_o;
  // LSB-first instance
  logic       l_data, l_valid, l_ready_i;
  logic       l_ready_o, l_valid_o;
  logic [7:0] l_data_o;
  logic [2:0] l_fill_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];

  always #5 sclk = ~sclk;

  sipo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .sclk_i(sclk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .fill_o(fill_o)
  );

  sipo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_l (
    .sclk_i(sclk), .rst_n_i(rst_n), .data_i(l_data), .valid_i(l_valid),
    .ready_o(l_ready_o), .data_o(l_data_o), .valid_o(l_valid_o),
    .ready_i(l_ready_i), .fill_o(l_fill_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Scoreboard: every word leaving either FIFO must match the queue head.
  always @(negedge sclk) begin
    logic [7:0] e;
    if (rst_n && valid_o && ready_i) begin
      e = (exp_m.size() > 0) ? exp_m.pop_front() : 8'hxx;
      chk("pop_msb", data_o, e);
    end
    if (rst_n && l_valid_o && l_ready_i) begin
      e = (exp_l.size() > 0) ? exp_l.pop_front() : 8'hxx;
      chk("pop_lsb", l_data_o, e);
    end
  end

  // Sends pat[7] first. With rnd set, inserts random valid gaps and
  // randomises ready_i each cycle so the link is back-pressured.
  task automatic send_bits(input logic [7:0] pat, input bit lsb, input int nbits,
                           input int gap_at, input int gap_len, input bit rnd);
    for (int i = 0; i < nbits; i++) begin
      int  guard;
      bit  acc;
      if (rnd) begin
        int g = $urandom_range(0, 2);
        valid_i = 1'b0;
        repeat (g) begin
          tick();
          ready_i = ($urandom_range(0, 3) == 0);
        end
      end
      if (lsb) begin l_data = pat[7-i]; l_valid = 1'b1; end
      else     begin data_i = pat[7-i]; valid_i = 1'b1; end
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard <= 200) begin
        acc = lsb ? l_ready_o : ready_o;
        tick();
        if (rnd) ready_i = ($urandom_range(0, 3) == 0);
        guard++;
      end
      chk("bit_accept_timeout", {31'd0, acc}, 32'd1);
      if (i + 1 == gap_at) begin
        valid_i = 1'b0;
        l_valid = 1'b0;
        repeat (gap_len) begin
          chk("gap_bit_cnt", lsb ? dut_l.r_bit_cnt : dut.r_bit_cnt, gap_at);
          tick();
        end
        chk("gap_bit_cnt_end", lsb ? dut_l.r_bit_cnt : dut.r_bit_cnt, gap_at);
      end
    end
    valid_i = 1'b0;
    l_valid = 1'b0;
    if (nbits == 8) begin
      if (lsb) exp_l.push_back(rev8(pat));
      else     exp_m.push_back(pat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    l_data = 1'b0; l_valid = 1'b0; l_ready_i = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_fill",  fill_o,  0);
    chk("rst_data",  data_o,  0);
    rst_n = 1'b1;
    tick();

    // Continuous A5, MSB-first
    ready_i = 1'b1;
    send_bits(8'hA5, 1'b0, 8, 0, 0, 1'b0);
    chk("lat_valid", valid_o, 1);
    chk("lat_data",  data_o,  8'hA5);
    tick();
    chk("popped_valid", valid_o, 0);

    // Gapped A5
    send_bits(8'hA5, 1'b0, 8, 4, 3, 1'b0);
    chk("gap_data", data_o, 8'hA5);
    tick();

    // LSB-first: palindrome and 01 -> 80
    send_bits(8'hA5, 1'b1, 8, 4, 3, 1'b0);
    chk("lsb_a5", l_data_o, 8'hA5);
    tick();
    send_bits(8'h01, 1'b1, 8, 0, 0, 1'b0);
    chk("lsb_01", l_data_o, 8'h80);
    tick();

    // Back-pressure
    ready_i = 1'b0;
    send_bits(8'h11, 1'b0, 8, 0, 0, 1'b0);
    chk("bp_fill1", fill_o, 1);
    send_bits(8'h22, 1'b0, 8, 0, 0, 1'b0);
    send_bits(8'h33, 1'b0, 8, 0, 0, 1'b0);
    send_bits(8'h44, 1'b0, 8, 0, 0, 1'b0);
    chk("bp_fill4", fill_o, 4);
    chk("bp_ready_before", ready_o, 1);
    send_bits(8'h55, 1'b0, 8, 0, 0, 1'b0);
    chk("stall_ready", ready_o, 0);
    chk("stall_fill",  fill_o,  4);
    chk("stall_head",  data_o,  8'h11);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("swap_fill",  fill_o,  4);
    chk("swap_ready", ready_o, 1);
    chk("swap_head",  data_o,  8'h22);

    // Drain ordering
    ready_i = 1'b1;
    chk("drain0", data_o, 8'h22); tick();
    chk("drain1", data_o, 8'h33); tick();
    chk("drain2", data_o, 8'h44); tick();
    chk("drain3", data_o, 8'h55); tick();
    chk("drain_valid", valid_o, 0);
    chk("drain_fill",  fill_o,  0);
    chk("drain_sb",    exp_m.size(), 0);

    // Reset mid-operation
    ready_i = 1'b0;
    send_bits(8'h12, 1'b0, 8, 0, 0, 1'b0);
    send_bits(8'h34, 1'b0, 8, 0, 0, 1'b0);
    send_bits(8'hFF, 1'b0, 5, 0, 0, 1'b0);
    chk("pre_rst_fill", fill_o, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_fill",  fill_o,  0);
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_ready", ready_o, 1);
    chk("async_rst_data",  data_o,  0);
    exp_m.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ready_i = 1'b1;
    send_bits(8'h3C, 1'b0, 8, 0, 0, 1'b0);
    chk("post_rst_data", data_o, 8'h3C);
    repeat (3) tick();
    chk("post_rst_sb",    exp_m.size(), 0);
    chk("post_rst_valid", valid_o, 0);

    // Loop-back of random bytes under random back-pressure
    ready_i = 1'b0;
    for (int n = 0; n < 10; n++) begin
      send_bits(8'($urandom), 1'b0, 8, 0, 0, 1'b1);
    end
    ready_i = 1'b1;
    for (int g = 0; g < 100 && (exp_m.size() != 0 || valid_o); g++) tick();
    chk("loop_sb_empty", exp_m.size(), 0);
    chk("loop_valid",    valid_o, 0);
    chk("loop_fill",     fill_o,  0);
    chk("lsb_sb_empty",  exp_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sipo
`default_nettype wire
